// File: rtl/arbiter_rr8.sv
// Eight-way round-robin arbiter with hold limit.
// One-hot grant is decoded from a registered winner index.
module arbiter_rr8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;
  logic [2:0]      win;
  logic [2:0]      cand;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win  = ptr_q;
    cand = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          state_d = BUSY;
          idx_d   = win;
          hold_d  = '0;
        end
      end
      BUSY: begin
        hold_d = hold_q + HW'(1);
        if (done) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant       = grant_valid ? (8'b1 << idx_q) : 8'h00;
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_arbiter_rr8.sv
// Directed scoreboard bench for arbiter_rr8.
// Runs with MAX_HOLD = 4 to reach the hold limit quickly.
module tb_arbiter_rr8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  arbiter_rr8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic       v;
    logic       t;
    logic [2:0] i;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    passed = 0;
  int    total  = 0;

  task automatic push(input string tag, input logic [7:0] g,
                      input logic t, input logic [2:0] i);
    exp_t e;
    e.g = g;
    e.v = (g != 8'h00);
    e.t = t;
    e.i = (g != 8'h00) ? i : 3'd0;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic chk();
    exp_t  e;
    exp_t  o;
    string tag;
    e   = sb.pop_front();
    tag = tags.pop_front();
    o.g = grant;
    o.v = grant_valid;
    o.t = timeout;
    o.i = grant_valid ? grant_idx : 3'd0;
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s obs g=%h v=%b t=%b i=%0d exp g=%h v=%b t=%b i=%0d",
                tag, o.g, o.v, o.t, o.i, e.g, e.v, e.t, e.i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] g,
                      input logic t, input logic [2:0] i);
    push(tag, g, t, i);
    tick();
    chk();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #23;
    push("reset", 8'h00, 1'b0, 3'd0);
    chk();

    @(negedge clk);
    req   = 8'b1000_0001;
    rst_n = 1'b1;
    step("first_grant", 8'h01, 1'b0, 3'd0);

    req = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      done = 1'b1;
      step("rot_idle", 8'h00, 1'b0, 3'd0);
      done = 1'b0;
      step("rot_grant", 8'h01 << (k % 8), 1'b0, 3'(k % 8));
    end

    done = 1'b1;
    step("pre5_idle", 8'h00, 1'b0, 3'd0);
    done = 1'b0;
    req  = 8'h20;
    step("own5", 8'h20, 1'b0, 3'd5);
    done = 1'b1;
    req  = 8'b0000_0110;
    step("rel5", 8'h00, 1'b0, 3'd0);
    done = 1'b0;
    step("skip_to1", 8'h02, 1'b0, 3'd1);
    done = 1'b1;
    step("rel1", 8'h00, 1'b0, 3'd0);
    done = 1'b0;
    step("ptr2_win2", 8'h04, 1'b0, 3'd2);
    done = 1'b1;
    step("rel2", 8'h00, 1'b0, 3'd0);

    done = 1'b0;
    req  = 8'h08;
    step("to_h0", 8'h08, 1'b0, 3'd3);
    step("to_h1", 8'h08, 1'b0, 3'd3);
    step("to_h2", 8'h08, 1'b0, 3'd3);
    step("to_h3", 8'h08, 1'b0, 3'd3);
    req = 8'hFF;
    step("to_pulse", 8'h00, 1'b1, 3'd0);
    step("to_next4", 8'h10, 1'b0, 3'd4);

    step("col_h1", 8'h10, 1'b0, 3'd4);
    step("col_h2", 8'h10, 1'b0, 3'd4);
    step("col_h3", 8'h10, 1'b0, 3'd4);
    done = 1'b1;
    step("col_rel", 8'h00, 1'b0, 3'd0);
    done = 1'b0;

    req = 8'h40;
    step("own6", 8'h40, 1'b0, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 8'h00, 1'b0, 3'd0);
    chk();
    @(negedge clk);
    req   = 8'hFF;
    rst_n = 1'b1;
    step("post_rst0", 8'h01, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbiter_rr8.md
# arbiter_rr8

Eight-way round-robin arbiter sharing one resource among eight requesters. It keeps a 3-bit winner index and decodes it into a one-hot grant vector, so at most one requester owns the resource at a time. It holds a grant until the owner signals completion or a hold limit expires, which guarantees forward progress. It sits between the requesting units and the shared resource's select/enable lines.

## Interface
Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit n = requester n.
- done  input  1  owner finished; sampled only in BUSY.
- grant  output  8  one-hot grant; bit n = requester n owns the resource; all-zero when none.
- grant_idx  output  3  binary index of the current owner; valid only while grant_valid = 1.
- grant_valid  output  1  high exactly when grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine, 2 states:
  - IDLE: no grant.
  - BUSY: grant held.
- Pointer ptr (3 bits): the requester with highest priority next. Reset value 0.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... ptr+7, with wrap-around mod 8.
  - Load grant_idx with the winner, go to BUSY, clear hold_cnt.
  - If req == 0, stay in IDLE.
- grant = decode(grant_idx) while BUSY, else 0. It is a pure one-hot decode of the registered index.
- BUSY:
  - hold_cnt increments each cycle; its width holds MAX_HOLD-1.
  - If done = 1, go to IDLE and set ptr = grant_idx+1 mod 8.
  - Otherwise, if hold_cnt == MAX_HOLD-1, go to IDLE, set ptr = grant_idx+1, and assert timeout for the following cycle.
  - Otherwise, stay in BUSY.
- done and the hold limit in the same cycle: done wins, no timeout pulse.
- The owner dropping its req while in BUSY has no effect; the grant is held until done or timeout.
- done while in IDLE is ignored.
- req changes while in BUSY do not affect the current grant; arbitration happens only in IDLE.
- One IDLE cycle always separates consecutive grants.
- Reset (rst_n low, any time, including mid-grant) takes effect immediately, with no clock edge needed:
  - state = IDLE, ptr = 0, grant_idx = 0, hold_cnt = 0.
  - grant = 0, grant_valid = 0, timeout = 0.
  - No pending state survives reset.

## Timing
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Arbitration latency: req sampled at edge k in IDLE → grant valid from just after edge k.
- Release: done = 1 sampled at edge m → grant = 0 after edge m.
  - A new grant appears at the earliest after edge m+1.
- Maximum hold: a grant is visible for at most MAX_HOLD cycles.
  - timeout is high for the one cycle immediately following the grant drop.
- Best case, a single requester with done asserted every BUSY cycle: grant period is 2 cycles (1 BUSY, 1 IDLE).
- Fairness: with all 8 requesting continuously, each requester is granted exactly once in every 8 consecutive grants.

## Test plan
- Reset and ptr priority:
  - Hold rst_n = 0 → grant = 00000000, grant_valid = 0, timeout = 0.
  - Release reset with req = 8'b1000_0001 → first grant to index 0 (grant bit 0), grant_idx = 0.
- Wrap-around rotation:
  - req = 8'hFF held, done pulsed one cycle after each grant.
  - Required grant_idx sequence: 0,1,2,3,4,5,6,7,0.
  - One idle cycle between grants.
- Priority skip:
  - After owner 5 completes (ptr = 6), req = 8'b0000_0110 → winner index 1.
  - Then, with ptr = 2 and the same req, the next winner is index 2.
- Timeout, MAX_HOLD = 4:
  - Grant index 3, done never asserted → grant held exactly 4 cycles.
  - timeout = 1 for one cycle, then the next arbitration starts from ptr = 4.
- Done vs limit collision:
  - done = 1 in the cycle where hold_cnt = MAX_HOLD-1 → release with timeout = 0.
- Asynchronous reset mid-grant:
  - Assert rst_n = 0 between clock edges while grant_idx = 6.
  - grant goes to 0 immediately, with no edge needed.
  - After reset release, arbitration restarts from ptr = 0.
